// File: rtl/mpd_io_cfg_loader.sv
// Serial configuration loader for fabric-configured IO pads.
// Frame: SYNC_WORD (16 bits), NUM_IO 12-bit words, 12-bit XOR checksum,
// all MSB first. A frame becomes visible on fabric_config only after its
// checksum matches. A frame that fails the check is dropped.
module mpd_io_cfg_loader #(
    parameter int          NUM_IO    = 38,
    parameter logic [15:0] SYNC_WORD = 16'hFAB0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic [12*NUM_IO-1:0]   fabric_config,
    output logic                   fabric_done,
    output logic                   cfg_busy,
    output logic                   cfg_error
);

    localparam int WIDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int BIT_W  = $clog2(12);

    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_IO - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(11);

    typedef enum logic [1:0] {
        HUNT,
        LOAD,
        CHECK
    } state_t;

    state_t              state;
    logic [15:0]         sync_sr;
    logic [11:0]         word_sr;
    logic [11:0]         csum;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WIDX_W-1:0]   word_idx;
    logic [12*NUM_IO-1:0] staging;

    logic [15:0]         sync_next;
    logic [11:0]         word_next;

    // Shift-register values including the bit offered this cycle
    always_comb begin
        sync_next = {sync_sr[14:0], cfg_bit};
        word_next = {word_sr[10:0], cfg_bit};
    end

    // Busy is a pure decode of the state register
    always_comb begin
        cfg_busy = (state != HUNT);
    end

    // Frame state machine: sync hunt, word load, checksum check and commit
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= HUNT;
            sync_sr       <= '0;
            word_sr       <= '0;
            csum          <= '0;
            bit_cnt       <= '0;
            word_idx      <= '0;
            staging       <= '0;
            fabric_config <= '0;
            fabric_done   <= 1'b0;
            cfg_error     <= 1'b0;
        end else if (cfg_valid) begin
            case (state)
                HUNT: begin
                    if (sync_next == SYNC_WORD) begin
                        state    <= LOAD;
                        sync_sr  <= '0;
                        word_sr  <= '0;
                        csum     <= '0;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                    end else begin
                        sync_sr <= sync_next;
                    end
                end

                LOAD: begin
                    if (bit_cnt == LAST_BIT) begin
                        staging[int'(word_idx)*12 +: 12] <= word_next;
                        csum    <= csum ^ word_next;
                        word_sr <= '0;
                        bit_cnt <= '0;
                        // Index holds at the last slot so it never leaves range
                        if (word_idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end else begin
                        word_sr <= word_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (word_next == csum) begin
                            fabric_config <= staging;
                            fabric_done   <= 1'b1;
                            cfg_error     <= 1'b0;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                        state    <= HUNT;
                        staging  <= '0;
                        sync_sr  <= '0;
                        word_sr  <= '0;
                        csum     <= '0;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                    end else begin
                        word_sr <= word_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= HUNT;
                    sync_sr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpd_io_cfg_loader.sv
// Directed bench for mpd_io_cfg_loader with NUM_IO=2.
module tb_mpd_io_cfg_loader;

    localparam int NUM_IO = 2;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_i;
    logic                 cfg_valid;
    logic                 cfg_bit;
    logic [12*NUM_IO-1:0] fabric_config;
    logic                 fabric_done;
    logic                 cfg_busy;
    logic                 cfg_error;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    mpd_io_cfg_loader #(
        .NUM_IO    (NUM_IO),
        .SYNC_WORD (16'hFAB0)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .cfg_valid     (cfg_valid),
        .cfg_bit       (cfg_bit),
        .fabric_config (fabric_config),
        .fabric_done   (fabric_done),
        .cfg_busy      (cfg_busy),
        .cfg_error     (cfg_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One valid bit, presented at the negedge, sampled by the next posedge
    task automatic drive_bit(input logic b);
        @(negedge wb_clk_i);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        @(posedge wb_clk_i);
        #1;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input int gap,
                             input bit check_busy, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            drive_bit(v[i]);
            if (check_busy) chk(tag, cfg_busy, 1);
        end
    endtask

    // Full frame; verifies busy throughout and that nothing commits early
    task automatic send_frame(input logic [11:0] w0, input logic [11:0] w1,
                              input logic [11:0] cs, input int gap,
                              input logic [23:0] old_cfg, input logic old_done);
        send_bits(16'hFAB0, 16, gap, 0, "sync");
        chk("busy_after_sync", cfg_busy, 1);
        send_bits({4'h0, w0}, 12, gap, 1, "busy_w0");
        send_bits({4'h0, w1}, 12, gap, 1, "busy_w1");
        send_bits({5'b0, cs[11:1]}, 11, gap, 1, "busy_cs");
        chk("cfg_before_commit", fabric_config, old_cfg);
        chk("done_before_commit", fabric_done, old_done);
        if (gap > 0) idle($urandom_range(0, gap));
        drive_bit(cs[0]);
        chk("busy_after_frame", cfg_busy, 0);
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        idle(3);
        wb_rst_i = 1'b0;
        chk("rst_cfg", fabric_config, 0);
        chk("rst_done", fabric_done, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_error, 0);

        // Garbage then a good frame, no gaps
        send_bits(16'h0016, 5, 0, 0, "garbage");
        chk("garbage_busy", cfg_busy, 0);
        send_frame(12'hA01, 12'h3C2, 12'h9C3, 0, 24'h0, 1'b0);
        chk("good_cfg", fabric_config, 24'h3C2A01);
        chk("good_done", fabric_done, 1);
        chk("good_err", cfg_error, 0);

        // Bad checksum: error set, committed state untouched
        send_frame(12'hFFF, 12'h000, 12'h000, 0, 24'h3C2A01, 1'b1);
        chk("bad_err", cfg_error, 1);
        chk("bad_cfg", fabric_config, 24'h3C2A01);
        chk("bad_done", fabric_done, 1);

        // Good frame after error, with idle gaps: error clears on commit
        send_frame(12'h123, 12'h456, 12'h575, 3, 24'h3C2A01, 1'b1);
        chk("recover_cfg", fabric_config, 24'h456123);
        chk("recover_err", cfg_error, 0);
        chk("recover_done", fabric_done, 1);

        // Original frame again with gaps
        send_frame(12'hA01, 12'h3C2, 12'h9C3, 3, 24'h456123, 1'b1);
        chk("gap_cfg", fabric_config, 24'h3C2A01);
        chk("gap_err", cfg_error, 0);

        // Sync pattern straddling the word boundary is data
        send_frame(12'h5FA, 12'hB07, 12'hEFD, 0, 24'h3C2A01, 1'b1);
        chk("embed_cfg", fabric_config, 24'hB075FA);
        chk("embed_err", cfg_error, 0);

        // Reset mid-frame, then a fresh frame
        send_bits(16'hFAB0, 16, 0, 0, "sync_abort");
        send_bits(16'h00FF, 8, 0, 1, "busy_abort");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        chk("midrst_cfg", fabric_config, 0);
        chk("midrst_done", fabric_done, 0);
        chk("midrst_busy", cfg_busy, 0);
        chk("midrst_err", cfg_error, 0);
        send_frame(12'h0AB, 12'h0CD, 12'h066, 0, 24'h0, 1'b0);
        chk("after_rst_cfg", fabric_config, 24'h0CD0AB);
        chk("after_rst_done", fabric_done, 1);
        chk("after_rst_err", cfg_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpd_io_cfg_loader.md
MPD_IO_CFG_LOADER -- requirements
Module: mpd_io_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_IO, default 38, meaning number of fabric-configured pads served.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hFAB0, meaning frame start pattern.
REQ-003 SHALL have port wb_clk_i  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  qualifies cfg_bit this cycle.
REQ-006 SHALL have port cfg_bit  input  1  serial config data, MSB first.
REQ-007 SHALL have port fabric_config  output  12*NUM_IO  committed per-pad words; pad k at bits [12k+11:12k].
REQ-008 SHALL have port fabric_done  output  1  committed config valid; drives every pad controller's fabric_done.
REQ-009 SHALL have port cfg_busy  output  1  frame in progress (state LOAD or CHECK).
REQ-010 SHALL have port cfg_error  output  1  sticky checksum-failure flag.

Function
REQ-011 SHALL consume exactly one bit per cycle with cfg_valid=1; cycles with cfg_valid=0 SHALL change no state.
REQ-012 SHALL implement states HUNT, LOAD, CHECK; reset state HUNT.
REQ-013 HUNT: shift accepted bits into a 16-bit register; move to LOAD in the cycle after the register equals SYNC_WORD; clear bit counter, word index, running checksum.
REQ-014 LOAD: shift bits into a 12-bit word register; after the 12th bit, write the word to staging slot word_index, XOR it into the 12-bit running checksum, increment word_index.
REQ-015 LOAD -> CHECK after word NUM_IO-1 completes; word_index SHALL never address beyond NUM_IO-1.
REQ-016 CHECK: receive a 12-bit checksum, MSB first; compare with the running checksum after the 12th bit.
REQ-017 On match: copy all staging slots to fabric_config and set fabric_done=1 in the same edge (1 cycle after the last checksum bit is sampled); clear cfg_error; go to HUNT.
REQ-018 On mismatch: set cfg_error=1; leave fabric_config and fabric_done unchanged; discard staging; go to HUNT.
REQ-019 fabric_config SHALL change only on a commit edge; no partially loaded word or frame SHALL ever be visible.
REQ-020 Once set, fabric_done SHALL stay 1 until reset; a later frame (good or bad) SHALL not deassert it.
REQ-021 Sync detection SHALL run only in HUNT; a SYNC_WORD pattern inside LOAD/CHECK data SHALL be treated as data.
REQ-022 The HUNT shift register SHALL be cleared on entry to HUNT so bits of a previous frame cannot form a sync match.
REQ-023 cfg_busy SHALL be 1 exactly when state is LOAD or CHECK.
REQ-024 Word and bit counters SHALL be sized as clog2 of their range (minimum 1 bit); arithmetic SHALL not wrap within a frame.

Reset
REQ-025 wb_rst_i=1 at a clock edge SHALL force: state HUNT, fabric_config all zeros, fabric_done=0, cfg_busy=0, cfg_error=0, counters, checksum, staging and shift registers zero.
REQ-026 Reset mid-frame SHALL abandon the frame; the next frame SHALL require a fresh SYNC_WORD.
REQ-027 No output SHALL depend combinationally on cfg_valid or cfg_bit.

Verification
REQ-028 NUM_IO=2: 5 garbage bits, then 16'hFAB0, 12'hA01, 12'h3C2, checksum 12'h9C3, all cfg_valid=1 -> fabric_config=24'h3C2A01 and fabric_done=1 one cycle after the last checksum bit; cfg_busy=0; cfg_error=0.
REQ-029 Same frame with random cfg_valid=0 gaps (up to 3 cycles) -> identical result; commit edge 1 cycle after the last valid checksum bit.
REQ-030 After REQ-028, frame with words 12'hFFF, 12'h000 and checksum 12'h000 -> cfg_error=1, fabric_config stays 24'h3C2A01, fabric_done stays 1.
REQ-031 Sync plus 8 word bits, then wb_rst_i for 1 cycle, then a full valid frame -> outputs zero after reset; second frame commits correctly; staging leftovers have no effect.
REQ-032 Word data containing 16'hFAB0 across a word boundary -> no resync; frame commits; cfg_busy=1 from the cycle after sync match until the commit edge.
REQ-033 Good frame after an erroring frame -> cfg_error clears on the commit edge; fabric_config takes the new words.
